// File: rtl/core_pipe_dispatch_pkg.sv
// Shared widths, operand-select encodings and op bundle for the dispatch stage.
// The select encodings are shared with the decoder so both sides agree on them.
package core_pipe_dispatch_pkg;

    localparam int XLEN       = 64;
    localparam int XL         = XLEN - 1;
    localparam int REG_ADDR_W = 5;
    localparam int INSTR_W    = 32;

    localparam int ALU_OP_W = 5;
    localparam int LSU_OP_W = 4;
    localparam int MDU_OP_W = 4;
    localparam int CSR_OP_W = 3;
    localparam int CFU_OP_W = 4;

    typedef enum logic [1:0] {
        OPA_SEL_RS1  = 2'd0,
        OPA_SEL_PC   = 2'd1,
        OPA_SEL_ZERO = 2'd2,
        OPA_SEL_RSVD = 2'd3
    } opa_sel_e;

    typedef enum logic {
        OPB_SEL_RS2 = 1'b0,
        OPB_SEL_IMM = 1'b1
    } opb_sel_e;

    typedef enum logic [1:0] {
        OPC_SEL_IMM  = 2'd0,
        OPC_SEL_RS2  = 2'd1,
        OPC_SEL_NPC  = 2'd2,
        OPC_SEL_ZERO = 2'd3
    } opc_sel_e;

    // All-zero means NOP in every field, which is what a bubble presents.
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu;
        logic [LSU_OP_W-1:0] lsu;
        logic [MDU_OP_W-1:0] mdu;
        logic [CSR_OP_W-1:0] csr;
        logic [CFU_OP_W-1:0] cfu;
        logic                op_w;
    } ops_t;

    // x0 is hardwired to zero, so a write to it never forwards.
    function automatic logic fwd_hit(
        input logic                  wen,
        input logic [REG_ADDR_W-1:0] waddr,
        input logic [REG_ADDR_W-1:0] raddr
    );
        return wen && (waddr != '0) && (waddr == raddr);
    endfunction

endpackage

// File: rtl/core_pipe_dispatch_if.sv
// Decoder / GPR file / execute signal bundle seen by the dispatch stage.
// master = surrounding pipeline, slave = dispatch stage.
interface core_pipe_dispatch_if;
    import core_pipe_dispatch_pkg::*;

    logic                  s1_valid;
    logic                  s1_ready;
    logic [XLEN-1:0]       s1_pc;
    logic [XLEN-1:0]       s1_npc;
    logic [INSTR_W-1:0]    s1_instr;
    logic [REG_ADDR_W-1:0] s1_rs1_a;
    logic [REG_ADDR_W-1:0] s1_rs2_a;
    logic [REG_ADDR_W-1:0] s1_rd;
    logic [XLEN-1:0]       s1_imm;
    logic [1:0]            s1_opa_sel;
    logic                  s1_opb_sel;
    logic [1:0]            s1_opc_sel;
    logic [ALU_OP_W-1:0]   s1_alu_op;
    logic [LSU_OP_W-1:0]   s1_lsu_op;
    logic [MDU_OP_W-1:0]   s1_mdu_op;
    logic [CSR_OP_W-1:0]   s1_csr_op;
    logic [CFU_OP_W-1:0]   s1_cfu_op;
    logic                  s1_op_w;

    logic [REG_ADDR_W-1:0] rf_rs1_a;
    logic [REG_ADDR_W-1:0] rf_rs2_a;
    logic [XLEN-1:0]       rf_rs1_d;
    logic [XLEN-1:0]       rf_rs2_d;

    logic                  s2_rd_wen;
    logic [REG_ADDR_W-1:0] s2_rd_addr;
    logic [XLEN-1:0]       s2_rd_wdata;
    logic                  s2_cf_valid;
    logic                  s2_cf_ack;

    logic                  s2_valid;
    logic                  s2_ready;
    logic [XLEN-1:0]       s2_pc;
    logic [XLEN-1:0]       s2_npc;
    logic [XLEN-1:0]       s2_opr_a;
    logic [XLEN-1:0]       s2_opr_b;
    logic [XLEN-1:0]       s2_opr_c;
    logic [REG_ADDR_W-1:0] s2_rd;
    logic [REG_ADDR_W-1:0] s2_rs1_a;
    logic [REG_ADDR_W-1:0] s2_rs2_a;
    logic [XLEN-1:0]       s2_rs1_d;
    logic [XLEN-1:0]       s2_rs2_d;
    logic [ALU_OP_W-1:0]   s2_alu_op;
    logic [LSU_OP_W-1:0]   s2_lsu_op;
    logic [MDU_OP_W-1:0]   s2_mdu_op;
    logic [CSR_OP_W-1:0]   s2_csr_op;
    logic [CFU_OP_W-1:0]   s2_cfu_op;
    logic                  s2_op_w;
    logic [INSTR_W-1:0]    s2_instr;

    modport master (
        output s1_valid, s1_pc, s1_npc, s1_instr, s1_rs1_a, s1_rs2_a, s1_rd, s1_imm,
               s1_opa_sel, s1_opb_sel, s1_opc_sel,
               s1_alu_op, s1_lsu_op, s1_mdu_op, s1_csr_op, s1_cfu_op, s1_op_w,
               rf_rs1_d, rf_rs2_d,
               s2_rd_wen, s2_rd_addr, s2_rd_wdata, s2_cf_valid, s2_cf_ack, s2_ready,
        input  s1_ready, rf_rs1_a, rf_rs2_a,
               s2_valid, s2_pc, s2_npc, s2_opr_a, s2_opr_b, s2_opr_c,
               s2_rd, s2_rs1_a, s2_rs2_a, s2_rs1_d, s2_rs2_d,
               s2_alu_op, s2_lsu_op, s2_mdu_op, s2_csr_op, s2_cfu_op, s2_op_w, s2_instr
    );

    modport slave (
        input  s1_valid, s1_pc, s1_npc, s1_instr, s1_rs1_a, s1_rs2_a, s1_rd, s1_imm,
               s1_opa_sel, s1_opb_sel, s1_opc_sel,
               s1_alu_op, s1_lsu_op, s1_mdu_op, s1_csr_op, s1_cfu_op, s1_op_w,
               rf_rs1_d, rf_rs2_d,
               s2_rd_wen, s2_rd_addr, s2_rd_wdata, s2_cf_valid, s2_cf_ack, s2_ready,
        output s1_ready, rf_rs1_a, rf_rs2_a,
               s2_valid, s2_pc, s2_npc, s2_opr_a, s2_opr_b, s2_opr_c,
               s2_rd, s2_rs1_a, s2_rs2_a, s2_rs1_d, s2_rs2_d,
               s2_alu_op, s2_lsu_op, s2_mdu_op, s2_csr_op, s2_cfu_op, s2_op_w, s2_instr
    );

endinterface

// File: rtl/core_pipe_dispatch_fwd.sv
// Source-operand value for one GPR read port: execute writeback bypass over the
// register file read data.
module core_pipe_dispatch_fwd
    import core_pipe_dispatch_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_rs_a,
    input  logic [XLEN-1:0]       i_rf_d,
    input  logic                  i_wb_wen,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0]       i_wb_wdata,
    output logic [XLEN-1:0]       o_rs_val
);

    logic w_hit;

    assign w_hit    = fwd_hit(i_wb_wen, i_wb_addr, i_rs_a);
    assign o_rs_val = w_hit ? i_wb_wdata : i_rf_d;

endmodule

// File: rtl/core_pipe_dispatch.sv
// Decode-to-execute pipeline register: GPR read, writeback forwarding, operand
// muxing, and wrong-path squash on an acknowledged execute control-flow change.
module core_pipe_dispatch
    import core_pipe_dispatch_pkg::*;
(
    input  logic               g_clk,
    input  logic               g_resetn,
    core_pipe_dispatch_if.slave bus
);

    logic                  r_s2_valid;
    logic [XLEN-1:0]       r_pc;
    logic [XLEN-1:0]       r_npc;
    logic [XLEN-1:0]       r_opr_a;
    logic [XLEN-1:0]       r_opr_b;
    logic [XLEN-1:0]       r_opr_c;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs1_a;
    logic [REG_ADDR_W-1:0] r_rs2_a;
    logic [XLEN-1:0]       r_rs1_d;
    logic [XLEN-1:0]       r_rs2_d;
    logic [INSTR_W-1:0]    r_instr;
    ops_t                  r_ops;

    logic                  w_flush;
    logic                  w_s1_ready;
    logic                  w_accept;
    logic                  w_valid_next;
    ops_t                  w_s1_ops;
    logic [XLEN-1:0]       w_opr_a;
    logic [XLEN-1:0]       w_opr_b;
    logic [XLEN-1:0]       w_opr_c;

    logic [REG_ADDR_W-1:0] w_rs_a   [2];
    logic [XLEN-1:0]       w_rf_d   [2];
    logic [XLEN-1:0]       w_rs_val [2];

    // A flush kills both the instruction in s2 and whatever s1 offers this cycle.
    assign w_flush    = bus.s2_cf_valid && bus.s2_cf_ack;
    assign w_s1_ready = !r_s2_valid || bus.s2_ready || w_flush;
    assign w_accept   = bus.s1_valid && w_s1_ready && !w_flush;

    always_comb begin
        w_valid_next = 1'b0;
        if (w_flush) begin
            w_valid_next = 1'b0;
        end else if (w_accept) begin
            w_valid_next = 1'b1;
        end else if (r_s2_valid && !bus.s2_ready) begin
            w_valid_next = 1'b1;
        end
    end

    assign w_rs_a[0] = bus.s1_rs1_a;
    assign w_rs_a[1] = bus.s1_rs2_a;
    assign w_rf_d[0] = bus.rf_rs1_d;
    assign w_rf_d[1] = bus.rf_rs2_d;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            core_pipe_dispatch_fwd u_fwd (
                .i_rs_a     (w_rs_a[gi]),
                .i_rf_d     (w_rf_d[gi]),
                .i_wb_wen   (bus.s2_rd_wen),
                .i_wb_addr  (bus.s2_rd_addr),
                .i_wb_wdata (bus.s2_rd_wdata),
                .o_rs_val   (w_rs_val[gi])
            );
        end
    endgenerate

    always_comb begin
        w_opr_a = '0;
        w_opr_b = '0;
        w_opr_c = '0;
        case (bus.s1_opa_sel)
            OPA_SEL_RS1: w_opr_a = w_rs_val[0];
            OPA_SEL_PC:  w_opr_a = bus.s1_pc;
            default:     w_opr_a = '0;
        endcase
        case (bus.s1_opb_sel)
            OPB_SEL_IMM: w_opr_b = bus.s1_imm;
            default:     w_opr_b = w_rs_val[1];
        endcase
        case (bus.s1_opc_sel)
            OPC_SEL_IMM: w_opr_c = bus.s1_imm;
            OPC_SEL_RS2: w_opr_c = w_rs_val[1];
            OPC_SEL_NPC: w_opr_c = bus.s1_npc;
            default:     w_opr_c = '0;
        endcase
    end

    assign w_s1_ops = '{
        alu:  bus.s1_alu_op,
        lsu:  bus.s1_lsu_op,
        mdu:  bus.s1_mdu_op,
        csr:  bus.s1_csr_op,
        cfu:  bus.s1_cfu_op,
        op_w: bus.s1_op_w
    };

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_s2_valid <= 1'b0;
            r_pc       <= '0;
            r_npc      <= '0;
            r_opr_a    <= '0;
            r_opr_b    <= '0;
            r_opr_c    <= '0;
            r_rd       <= '0;
            r_rs1_a    <= '0;
            r_rs2_a    <= '0;
            r_rs1_d    <= '0;
            r_rs2_d    <= '0;
            r_instr    <= '0;
            r_ops      <= '0;
        end else begin
            r_s2_valid <= w_valid_next;
            if (w_accept) begin
                r_pc    <= bus.s1_pc;
                r_npc   <= bus.s1_npc;
                r_opr_a <= w_opr_a;
                r_opr_b <= w_opr_b;
                r_opr_c <= w_opr_c;
                r_rd    <= bus.s1_rd;
                r_rs1_a <= bus.s1_rs1_a;
                r_rs2_a <= bus.s1_rs2_a;
                r_rs1_d <= w_rs_val[0];
                r_rs2_d <= w_rs_val[1];
                r_instr <= bus.s1_instr;
            end
            // Execute decodes ops without looking at valid, so bubbles carry NOPs.
            if (!w_valid_next) begin
                r_ops <= '0;
            end else if (w_accept) begin
                r_ops <= w_s1_ops;
            end
        end
    end

    assign bus.s1_ready  = w_s1_ready;
    assign bus.rf_rs1_a  = bus.s1_rs1_a;
    assign bus.rf_rs2_a  = bus.s1_rs2_a;
    assign bus.s2_valid  = r_s2_valid;
    assign bus.s2_pc     = r_pc;
    assign bus.s2_npc    = r_npc;
    assign bus.s2_opr_a  = r_opr_a;
    assign bus.s2_opr_b  = r_opr_b;
    assign bus.s2_opr_c  = r_opr_c;
    assign bus.s2_rd     = r_rd;
    assign bus.s2_rs1_a  = r_rs1_a;
    assign bus.s2_rs2_a  = r_rs2_a;
    assign bus.s2_rs1_d  = r_rs1_d;
    assign bus.s2_rs2_d  = r_rs2_d;
    assign bus.s2_instr  = r_instr;
    assign bus.s2_alu_op = r_ops.alu;
    assign bus.s2_lsu_op = r_ops.lsu;
    assign bus.s2_mdu_op = r_ops.mdu;
    assign bus.s2_csr_op = r_ops.csr;
    assign bus.s2_cfu_op = r_ops.cfu;
    assign bus.s2_op_w   = r_ops.op_w;

endmodule

// File: tb/tb_core_pipe_dispatch.sv
// Scoreboard bench for core_pipe_dispatch: directed scenarios then random traffic,
// with expected s2 bundles queued at issue and compared by a negedge monitor.
module tb_core_pipe_dispatch;
    import core_pipe_dispatch_pkg::*;

    typedef struct {
        logic [XLEN-1:0]       pc, npc, a, b, c, rs1_d, rs2_d;
        logic [REG_ADDR_W-1:0] rd, rs1_a, rs2_a;
        logic [INSTR_W-1:0]    instr;
        logic [ALU_OP_W-1:0]   alu;
        logic [LSU_OP_W-1:0]   lsu;
        logic [MDU_OP_W-1:0]   mdu;
        logic [CSR_OP_W-1:0]   csr;
        logic [CFU_OP_W-1:0]   cfu;
        logic                  opw;
        int                    avail;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   occ = 0;
    bit   rst_prev = 0;
    bit   dp_zero = 1;
    bit   exp_s1_ready = 1;
    exp_t sb_q[$];

    core_pipe_dispatch_if bus ();

    core_pipe_dispatch dut (
        .g_clk    (clk),
        .g_resetn (resetn),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference: forwarded source values and operand selection from the rules.
    function automatic exp_t model();
        exp_t e;
        logic [XLEN-1:0] v1, v2;
        v1 = (bus.s2_rd_wen && bus.s2_rd_addr != 0 && bus.s2_rd_addr == bus.s1_rs1_a)
             ? bus.s2_rd_wdata : bus.rf_rs1_d;
        v2 = (bus.s2_rd_wen && bus.s2_rd_addr != 0 && bus.s2_rd_addr == bus.s1_rs2_a)
             ? bus.s2_rd_wdata : bus.rf_rs2_d;
        e.pc = bus.s1_pc; e.npc = bus.s1_npc; e.rs1_d = v1; e.rs2_d = v2;
        e.a  = (bus.s1_opa_sel == 0) ? v1 : (bus.s1_opa_sel == 1) ? bus.s1_pc : '0;
        e.b  = bus.s1_opb_sel ? bus.s1_imm : v2;
        e.c  = (bus.s1_opc_sel == 0) ? bus.s1_imm : (bus.s1_opc_sel == 1) ? v2 :
               (bus.s1_opc_sel == 2) ? bus.s1_npc : '0;
        e.rd = bus.s1_rd; e.rs1_a = bus.s1_rs1_a; e.rs2_a = bus.s1_rs2_a;
        e.instr = bus.s1_instr;
        e.alu = bus.s1_alu_op; e.lsu = bus.s1_lsu_op; e.mdu = bus.s1_mdu_op;
        e.csr = bus.s1_csr_op; e.cfu = bus.s1_cfu_op; e.opw = bus.s1_op_w;
        e.avail = 0;
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_prev) begin
            sb_q.delete();
            dp_zero  = 1;
            rst_prev = 0;
        end
    endtask

    // Called once per cycle after inputs are driven: decide acceptance and queue.
    task automatic step();
        bit flush, acc;
        exp_t e;
        flush = bus.s2_cf_valid && bus.s2_cf_ack;
        exp_s1_ready = !occ || bus.s2_ready || flush;
        if (!resetn) begin
            occ = 0;
            rst_prev = 1;
        end else begin
            acc = bus.s1_valid && exp_s1_ready && !flush;
            if (acc) begin
                e = model();
                e.avail = cyc + 1;
                sb_q.push_back(e);
                dp_zero = 0;
            end
            occ = flush ? 1'b0 : acc ? 1'b1 : (occ && !bus.s2_ready);
        end
    endtask

    task automatic clear_inputs();
        resetn = 1'b1;
        bus.s1_valid = 0; bus.s1_pc = 0; bus.s1_npc = 0; bus.s1_instr = 0;
        bus.s1_rs1_a = 0; bus.s1_rs2_a = 0; bus.s1_rd = 0; bus.s1_imm = 0;
        bus.s1_opa_sel = 0; bus.s1_opb_sel = 0; bus.s1_opc_sel = 0;
        bus.s1_alu_op = 0; bus.s1_lsu_op = 0; bus.s1_mdu_op = 0;
        bus.s1_csr_op = 0; bus.s1_cfu_op = 0; bus.s1_op_w = 0;
        bus.rf_rs1_d = 0; bus.rf_rs2_d = 0;
        bus.s2_rd_wen = 0; bus.s2_rd_addr = 0; bus.s2_rd_wdata = 0;
        bus.s2_cf_valid = 0; bus.s2_cf_ack = 0; bus.s2_ready = 1;
    endtask

    task automatic rand_inputs();
        resetn = ($urandom_range(0, 99) != 0);
        bus.s1_valid   = ($urandom_range(0, 3) != 0);
        bus.s1_pc      = {$urandom(), $urandom()};
        bus.s1_npc     = bus.s1_pc + 64'd4;
        bus.s1_instr   = $urandom();
        bus.s1_rs1_a   = REG_ADDR_W'($urandom_range(0, 7));
        bus.s1_rs2_a   = REG_ADDR_W'($urandom_range(0, 7));
        bus.s1_rd      = REG_ADDR_W'($urandom_range(0, 31));
        bus.s1_imm     = {$urandom(), $urandom()};
        bus.s1_opa_sel = 2'($urandom_range(0, 3));
        bus.s1_opb_sel = 1'($urandom_range(0, 1));
        bus.s1_opc_sel = 2'($urandom_range(0, 3));
        bus.s1_alu_op  = ALU_OP_W'($urandom());
        bus.s1_lsu_op  = LSU_OP_W'($urandom());
        bus.s1_mdu_op  = MDU_OP_W'($urandom());
        bus.s1_csr_op  = CSR_OP_W'($urandom());
        bus.s1_cfu_op  = CFU_OP_W'($urandom());
        bus.s1_op_w    = 1'($urandom_range(0, 1));
        bus.rf_rs1_d   = (bus.s1_rs1_a == 0) ? '0 : {$urandom(), $urandom()};
        bus.rf_rs2_d   = (bus.s1_rs2_a == 0) ? '0 : {$urandom(), $urandom()};
        bus.s2_rd_wen  = 1'($urandom_range(0, 1));
        bus.s2_rd_addr = REG_ADDR_W'($urandom_range(0, 7));
        bus.s2_rd_wdata = {$urandom(), $urandom()};
        bus.s2_ready   = ($urandom_range(0, 3) != 0);
        bus.s2_cf_valid = ($urandom_range(0, 6) == 0);
        bus.s2_cf_ack  = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            clear_inputs();
            step();
        end
    endtask

    // Monitor: compare the presented s2 bundle against the scoreboard head.
    initial begin
        exp_t e;
        bit   ev;
        forever begin
            @(negedge clk);
            if (cyc == 0) continue;
            chk("s1_ready", bus.s1_ready, exp_s1_ready);
            chk("rf_rs1_a", bus.rf_rs1_a, bus.s1_rs1_a);
            chk("rf_rs2_a", bus.rf_rs2_a, bus.s1_rs2_a);
            ev = (sb_q.size() > 0) && (sb_q[0].avail <= cyc);
            chk("s2_valid", bus.s2_valid, ev);
            if (ev) begin
                e = sb_q[0];
                chk("s2_pc", bus.s2_pc, e.pc);
                chk("s2_npc", bus.s2_npc, e.npc);
                chk("s2_opr_a", bus.s2_opr_a, e.a);
                chk("s2_opr_b", bus.s2_opr_b, e.b);
                chk("s2_opr_c", bus.s2_opr_c, e.c);
                chk("s2_rs1_d", bus.s2_rs1_d, e.rs1_d);
                chk("s2_rs2_d", bus.s2_rs2_d, e.rs2_d);
                chk("s2_rd", bus.s2_rd, e.rd);
                chk("s2_rs1_a", bus.s2_rs1_a, e.rs1_a);
                chk("s2_rs2_a", bus.s2_rs2_a, e.rs2_a);
                chk("s2_instr", bus.s2_instr, e.instr);
                chk("s2_ops", {bus.s2_alu_op, bus.s2_lsu_op, bus.s2_mdu_op, bus.s2_csr_op,
                               bus.s2_cfu_op, bus.s2_op_w},
                              {e.alu, e.lsu, e.mdu, e.csr, e.cfu, e.opw});
                if (bus.s2_cf_valid && bus.s2_cf_ack) begin
                    $display("txn cyc=%0d pc=%h squashed", cyc, e.pc);
                    void'(sb_q.pop_front());
                end else if (bus.s2_ready) begin
                    $display("txn cyc=%0d pc=%h a=%h b=%h c=%h", cyc, e.pc, e.a, e.b, e.c);
                    void'(sb_q.pop_front());
                end
            end else begin
                chk("bubble_ops", {bus.s2_alu_op, bus.s2_lsu_op, bus.s2_mdu_op, bus.s2_csr_op,
                                   bus.s2_cfu_op, bus.s2_op_w}, '0);
                if (dp_zero) begin
                    chk("rst_pc", bus.s2_pc, '0);
                    chk("rst_opr", bus.s2_opr_a | bus.s2_opr_b | bus.s2_opr_c, '0);
                    chk("rst_misc", {bus.s2_npc | bus.s2_rs1_d | bus.s2_rs2_d,
                                     bus.s2_rd, bus.s2_rs1_a, bus.s2_rs2_a}, '0);
                    chk("rst_instr", bus.s2_instr, '0);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            clear_inputs();
            resetn = 1'b0;
            step();
        end
        idle(1);

        // Forward x5=7 from execute into add x6,x5,x5 while the GPR file is stale.
        next_cycle(); clear_inputs();
        bus.s1_valid = 1; bus.s1_rs1_a = 5; bus.s1_rs2_a = 5; bus.s1_rd = 6;
        bus.s1_alu_op = 5'h01;
        bus.s2_rd_wen = 1; bus.s2_rd_addr = 5; bus.s2_rd_wdata = 64'd7;
        step();
        next_cycle();
        chk("fwd_opr_a", bus.s2_opr_a, 64'd7);
        chk("fwd_opr_b", bus.s2_opr_b, 64'd7);
        chk("fwd_rs1_d", bus.s2_rs1_d, 64'd7);
        clear_inputs();
        // Writes to x0 never forward.
        bus.s1_valid = 1; bus.s1_rs1_a = 0; bus.s1_alu_op = 5'h01;
        bus.s2_rd_wen = 1; bus.s2_rd_addr = 0; bus.s2_rd_wdata = 64'hDEAD;
        step();
        next_cycle();
        chk("x0_opr_a", bus.s2_opr_a, 64'd0);
        clear_inputs(); step();

        // Load stalls in s2 for three cycles; dependent add waits, then forwards 0x55.
        next_cycle(); clear_inputs();
        bus.s1_valid = 1; bus.s1_rs1_a = 2; bus.s1_rd = 6; bus.s1_opb_sel = 1;
        bus.s1_imm = 64'h10; bus.s1_lsu_op = 4'h3; bus.rf_rs1_d = 64'h1000;
        step();
        for (int i = 0; i < 3; i++) begin
            next_cycle(); clear_inputs();
            bus.s2_ready = 0; bus.s1_valid = 1; bus.s1_rs1_a = 6; bus.s1_rs2_a = 6;
            bus.s1_rd = 7; bus.s1_alu_op = 5'h01;
            step();
        end
        next_cycle(); clear_inputs();
        bus.s1_valid = 1; bus.s1_rs1_a = 6; bus.s1_rs2_a = 6; bus.s1_rd = 7;
        bus.s1_alu_op = 5'h01;
        bus.s2_rd_wen = 1; bus.s2_rd_addr = 6; bus.s2_rd_wdata = 64'h55;
        step();
        next_cycle();
        chk("stall_fwd_a", bus.s2_opr_a, 64'h55);
        chk("stall_fwd_b", bus.s2_opr_b, 64'h55);
        clear_inputs(); step();

        // jal: opc=npc, then an acknowledged flush squashes it and the s1 offer.
        next_cycle(); clear_inputs();
        bus.s1_valid = 1; bus.s1_pc = 64'h8000_0000; bus.s1_npc = 64'h8000_0004;
        bus.s1_opa_sel = 1; bus.s1_opb_sel = 1; bus.s1_imm = 64'h100; bus.s1_opc_sel = 2;
        bus.s1_alu_op = 5'h01; bus.s1_cfu_op = 4'h1;
        step();
        next_cycle();
        chk("jal_opr_c", bus.s2_opr_c, 64'h8000_0004);
        clear_inputs();
        bus.s2_ready = 0; bus.s2_cf_valid = 1; bus.s2_cf_ack = 1;
        bus.s1_valid = 1; bus.s1_alu_op = 5'h02; bus.s1_cfu_op = 4'h2;
        step();
        next_cycle();
        chk("flush_valid", bus.s2_valid, 0);
        chk("flush_cfu", bus.s2_cfu_op, 0);
        chk("flush_alu", bus.s2_alu_op, 0);
        // sw: opc=rs2 carries store data.
        clear_inputs();
        bus.s1_valid = 1; bus.s1_rs2_a = 9; bus.rf_rs2_d = 64'h1234; bus.s1_opc_sel = 1;
        bus.s1_lsu_op = 4'h8;
        step();
        next_cycle();
        chk("sw_opr_c", bus.s2_opr_c, 64'h1234);
        clear_inputs(); step();

        // Reset lands while a branch sits in s2.
        next_cycle(); clear_inputs();
        bus.s1_valid = 1; bus.s1_pc = 64'h4000; bus.s1_cfu_op = 4'h3; bus.s1_alu_op = 5'h04;
        step();
        next_cycle();
        chk("br_valid", bus.s2_valid, 1);
        clear_inputs();
        resetn = 0; bus.s2_ready = 0; bus.s1_valid = 1; bus.s1_pc = 64'h5000;
        step();
        next_cycle();
        chk("rst_valid", bus.s2_valid, 0);
        chk("rst_pc_dir", bus.s2_pc, 0);
        chk("rst_cfu", bus.s2_cfu_op, 0);
        clear_inputs(); step();

        for (int i = 0; i < 1500; i++) begin
            next_cycle();
            rand_inputs();
            step();
        end
        idle(3);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_pipe_dispatch.md
Name: core_pipe_dispatch

Overview:
- Decode-to-execute pipeline register of the in-order core.
- Takes decoded instruction fields from the combinational decoder (stage s1) and reads the GPR file.
- Resolves operand forwarding from the execute-stage writeback port and muxes operands a/b/c.
- Holds the s2_* bundle stable for the execute stage; drops wrong-path instructions on an execute control-flow change.

Parameters:
- XLEN, 64, datapath width (XL = XLEN-1).
- REG_ADDR_W, 5, GPR address width.
- ALU_OP_W / LSU_OP_W / MDU_OP_W / CSR_OP_W / CFU_OP_W, from core_common, operation field widths.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  synchronous active-low reset
- s1_valid  in  1  decoded instruction valid
- s1_ready  out  1  dispatch accepts s1 this cycle
- s1_pc / s1_npc  in  XLEN  instruction PC / PC of next sequential instruction
- s1_instr  in  32  encoded instruction
- s1_rs1_a / s1_rs2_a / s1_rd  in  5  source and destination register addresses
- s1_imm  in  XLEN  sign-extended immediate
- s1_opa_sel  in  2  0=rs1, 1=pc, 2=zero, 3=reserved (zero)
- s1_opb_sel  in  1  0=rs2, 1=imm
- s1_opc_sel  in  2  0=imm, 1=rs2, 2=npc, 3=zero
- s1_alu_op / s1_lsu_op / s1_mdu_op / s1_csr_op / s1_cfu_op  in  op widths  operation fields
- s1_op_w  in  1  word operation
- rf_rs1_a / rf_rs2_a  out  5  GPR read addresses; equal to s1_rs1_a / s1_rs2_a, combinational
- rf_rs1_d / rf_rs2_d  in  XLEN  GPR read data, same cycle; x0 reads 0
- s2_rd_wen / s2_rd_addr / s2_rd_wdata  in  1/5/XLEN  execute GPR write port (forward source)
- s2_cf_valid / s2_cf_ack  in  1/1  execute control-flow change and its acknowledge
- s2_valid  out  1  registered instruction valid
- s2_ready  in  1  execute ready for new instruction
- s2_pc, s2_npc, s2_opr_a, s2_opr_b, s2_opr_c  out  XLEN  registered PC, next PC and operands
- s2_rd, s2_rs1_a, s2_rs2_a  out  5  registered register addresses
- s2_rs1_d, s2_rs2_d  out  XLEN  registered forwarded source values
- s2_alu_op, s2_lsu_op, s2_mdu_op, s2_csr_op, s2_cfu_op, s2_op_w, s2_instr  out  as s1  registered fields

Behaviour:
- Reset: every s2_* output register is cleared to 0, so s2_valid=0 and all op fields are NOP. Reset applies mid-operation without exception.
- flush = s2_cf_valid && s2_cf_ack.
- s1_ready = !s2_valid || s2_ready || flush. The s1 instruction is discarded on flush; fetch redirects it.
- accept = s1_valid && s1_ready && !flush.
- Next s2_valid:
  - 0 on flush;
  - else 1 on accept;
  - else 1 if s2_valid && !s2_ready;
  - else 0.
- Datapath fields (pc, npc, operands, addresses, instr) load only on accept and otherwise hold.
- Op fields (alu/lsu/mdu/csr/cfu, op_w) load on accept. They are forced to 0 in any cycle where next s2_valid=0.
  - Reason: execute decodes cfu ops without gating by valid, so a bubble must never present a stale jump.
- Forwarding, per source n in {1,2}: fwd_n = s2_rd_wen && s2_rd_addr != 0 && s2_rd_addr == s1_rsn_a.
  - rsn_val = fwd_n ? s2_rd_wdata : rf_rsn_d.
  - There is no other hazard logic. Once execute has written a register, the GPR file already holds the value.
- Operand mux (on rsn_val):
  - opr_a = rs1 | pc | 0.
  - opr_b = rs2 | imm.
  - opr_c = imm | rs2 | npc | 0.
- Latency: one cycle s1 to s2. Throughput is one instruction per cycle while s2_ready=1.
- Simultaneous flush and s1_valid: the s1 instruction is dropped and s2 becomes a bubble, even when s2_ready=1.
- s2_valid=0 with s2_ready=0 from execute: s1 is still accepted, because s1_ready depends on !s2_valid.

Decomposition:
- Operand select encodings (OPA_SEL_*, OPB_SEL_*, OPC_SEL_*) go in core_common.svh next to the ALU_OP/CFU_OP constants; they are shared with the decoder.
- One sub-module, core_pipe_dispatch_fwd: combinational forwarding and mux for a single source operand, instanced twice.

Test Plan:
- addi x5,x0,7 executing (s2_rd_wen=1, addr 5, wdata 7) while s1 holds add x6,x5,x5 with rf_rs1_d=0 -> next cycle s2_opr_a=7, s2_opr_b=7, s2_rs1_d=7.
- s2_rd_wen=1, s2_rd_addr=0, wdata=0xDEAD, s1 reads x0 -> s2_opr_a=0; no forward from x0.
- Load in s2 with s2_ready=0 for 3 cycles, s1_valid=1 -> s1_ready=0 throughout and s2_* stable. On the 4th cycle ready=1 and wen=1 with wdata=0x55 -> dependent s1 captures 0x55.
- s2 holds jal, s2_cf_valid=1 with ack=1 and s1_valid=1 -> s1_ready=1, next s2_valid=0, s2_cfu_op=0, s2_alu_op=0.
- jal with s1_opc_sel=npc, s1_npc=0x8000_0004 -> s2_opr_c=0x8000_0004. sw with opc_sel=rs2, rf_rs2_d=0x1234 -> s2_opr_c=0x1234.
- g_resetn=0 asserted while s2_valid=1 with a branch latched -> next cycle s2_valid=0 and all s2_* fields 0.
